// File: rtl/vend_pkg.sv
// vend_pkg
//   Shared definitions for the vending machine front end and the vending FSM.
//   Coin codes are the single encoding used on the 2-bit coin bus between
//   coin_acceptor and the vending FSM.
//   No ports (package).
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StEmit    = 2'b01,
      StLockout = 2'b10
   } coin_acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce
//   Per-line front end: 2-flop synchroniser, counting debouncer and a
//   rising-edge strobe on the debounced level.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   raw  - asynchronous, possibly bouncing sensor line
//   rise - one-cycle strobe in the cycle after the debounced level goes high
module coin_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic             deb_d1_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter tracks how long the synchronised level has disagreed with the
   // debounced level; any agreement restarts the count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = ~deb_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         deb_q    <= 1'b0;
         deb_d1_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         deb_d1_q <= deb_q;
         cnt_q    <= cnt_d;
      end
   end

   // Derived from flops only, so the FSM can act on it at the next edge.
   assign rise = deb_q & ~deb_d1_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Turns debounced coin insertions into one-cycle coin codes for the vending
//   FSM, rejecting simultaneous or too-closely-spaced insertions.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   coin5_raw  - 5 rs slot sensor (asynchronous, may bounce)
//   coin10_raw - 10 rs slot sensor (asynchronous, may bounce)
//   coin_code  - registered coin code, non-zero for one cycle per accepted coin
//   reject     - registered one-cycle pulse when a coin event is discarded
//   busy       - high while in EMIT or LOCKOUT
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LOCKOUT_CYCLES  = 8,
   parameter int unsigned CNT_W           = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   output logic [1:0] coin_code,
   output logic       reject,
   output logic       busy
);

   logic ev5, ev10;

   coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb5 (
      .clk  (clk),
      .rst  (rst),
      .raw  (coin5_raw),
      .rise (ev5)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb10 (
      .clk  (clk),
      .rst  (rst),
      .raw  (coin10_raw),
      .rise (ev10)
   );

   coin_acc_state_t  state_q, state_d;
   logic [1:0]       code_q, code_d;
   logic             reject_q, reject_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   always_comb begin
      state_d    = state_q;
      code_d     = COIN_NONE;
      reject_d   = 1'b0;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ev5 && ev10) begin
               // Ambiguous insertion: neither coin is credited.
               reject_d   = 1'b1;
               lock_cnt_d = CNT_W'(LOCKOUT_CYCLES);
               state_d    = StLockout;
            end else if (ev5) begin
               code_d  = COIN_5;
               state_d = StEmit;
            end else if (ev10) begin
               code_d  = COIN_10;
               state_d = StEmit;
            end
         end
         StEmit: begin
            reject_d   = ev5 | ev10;
            lock_cnt_d = CNT_W'(LOCKOUT_CYCLES);
            state_d    = StLockout;
         end
         StLockout: begin
            // Discarded events do not restart the lockout.
            reject_d = ev5 | ev10;
            if (lock_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               lock_cnt_d = lock_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         code_q     <= COIN_NONE;
         reject_q   <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         reject_q   <= reject_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign coin_code = code_q;
   assign reject    = reject_q;
   assign busy      = (state_q != StIdle);

endmodule
